// File: rtl/div_ctrl.sv
// Iterative 32-bit integer divider controller for the EX stage.
// Restoring shift-subtract over 32 cycles with signed fix-up and divide-by-zero bypass.
module div_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        flush,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] result,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        ITER  = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, state_next;

    logic [1:0]  op_q;
    logic [31:0] src1_q;
    logic [31:0] src2_q;
    logic [31:0] divisor_q;
    logic [31:0] quo_q;
    logic [63:0] pr_q;
    logic [5:0]  cnt_q;
    logic        quo_neg_q;
    logic        rem_neg_q;

    logic        op_signed;
    logic        op_rem;
    logic        src1_neg;
    logic        src2_neg;
    logic [31:0] src1_abs;
    logic [31:0] src2_abs;
    logic [32:0] trial_top;
    logic        trial_fits;
    logic [31:0] trial_diff;

    // op[1] selects unsigned, op[0] selects remainder.
    assign op_signed = ~op_q[1];
    assign op_rem    = op_q[0];

    assign src1_neg = op_signed & src1_q[31];
    assign src2_neg = op_signed & src2_q[31];
    assign src1_abs = src1_neg ? (~src1_q + 32'd1) : src1_q;
    assign src2_abs = src2_neg ? (~src2_q + 32'd1) : src2_q;

    // The shifted partial remainder needs 33 bits: pr[63] would otherwise be lost.
    // When the trial fits, the true difference is below 2^32, so the low 32 bits suffice.
    assign trial_top  = pr_q[63:31];
    assign trial_fits = (trial_top >= {1'b0, divisor_q});
    assign trial_diff = trial_top[31:0] - divisor_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        req_ready  = (state == IDLE) & ~flush;
        busy       = (state != IDLE);
        res_valid  = (state == DONE);
        result     = '0;

        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state_next = PREP;
                    end
                end
                PREP: begin
                    state_next = (src2_q == 32'd0) ? DONE : ITER;
                end
                ITER: begin
                    if (cnt_q == 6'd1) begin
                        state_next = FIXUP;
                    end
                end
                FIXUP: begin
                    state_next = DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        if (state == DONE) begin
            result = op_rem ? pr_q[63:32] : quo_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
            pr_q      <= '0;
            cnt_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q   <= req_op;
                        src1_q <= req_src1;
                        src2_q <= req_src2;
                    end
                end
                PREP: begin
                    quo_neg_q <= src1_neg ^ src2_neg;
                    rem_neg_q <= src1_neg;
                    divisor_q <= src2_abs;
                    cnt_q     <= 6'd32;
                    if (src2_q == 32'd0) begin
                        // Divide-by-zero: all-ones quotient, raw dividend as remainder.
                        quo_q <= '1;
                        pr_q  <= {src1_q, 32'd0};
                    end else begin
                        quo_q <= '0;
                        pr_q  <= {32'd0, src1_abs};
                    end
                end
                ITER: begin
                    cnt_q <= cnt_q - 6'd1;
                    if (trial_fits) begin
                        pr_q  <= {trial_diff, pr_q[30:0], 1'b0};
                        quo_q <= {quo_q[30:0], 1'b1};
                    end else begin
                        pr_q  <= {pr_q[62:0], 1'b0};
                        quo_q <= {quo_q[30:0], 1'b0};
                    end
                end
                FIXUP: begin
                    if (quo_neg_q) begin
                        quo_q <= ~quo_q + 32'd1;
                    end
                    if (rem_neg_q) begin
                        pr_q[63:32] <= ~pr_q[63:32] + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    a_result_zero_idle: assert property (@(posedge clk) disable iff (reset)
        !res_valid |-> (result == 32'd0));

    a_result_stable: assert property (@(posedge clk) disable iff (reset)
        (res_valid && !res_ready && !flush) |=> (res_valid && $stable(result)));

    a_iter_count: assert property (@(posedge clk) disable iff (reset)
        (state == ITER) |-> (cnt_q != 6'd0));

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The block SHALL run on one clock, and reset SHALL be asynchronous and active-high.
REQ-002 clk  in  1  pipeline clock; all state SHALL change on its rising edge.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 req_valid  in  1  EX stage presents a divide operation.
REQ-005 req_ready  out  1  controller accepts the operation this cycle.
REQ-006 req_op  in  2  operation select: 00 DIV.W, 01 MOD.W, 10 DIV.WU, 11 MOD.WU.
REQ-007 req_src1  in  32  dividend.
REQ-008 req_src2  in  32  divisor.
REQ-009 flush  in  1  kill the in-flight operation (exception or ertn).
REQ-010 res_valid  out  1  result available.
REQ-011 res_ready  in  1  EX stage consumes the result.
REQ-012 result  out  32  quotient or remainder, as selected by the latched req_op.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 The state machine SHALL have states IDLE, PREP, ITER, FIXUP and DONE, encoded in 3 bits.
REQ-015 req_ready SHALL equal (state==IDLE) & ~flush.
REQ-016 Accept SHALL be req_valid & req_ready at edge T, which latches op, src1 and src2 and moves to PREP.
REQ-017 PREP (T+1) SHALL latch the absolute values of both operands for signed ops, or the raw values for unsigned ops, and record the quotient and remainder sign bits.
REQ-018 PREP SHALL load a 6-bit iteration counter with 32 and go to ITER, or go to DONE if src2==0.
REQ-019 ITER SHALL perform one restoring shift-subtract step per cycle on a 64-bit partial remainder and a 32-bit quotient, decrement the counter, and go to FIXUP when the counter reaches 0; ITER lasts 32 cycles (T+2..T+33).
REQ-020 FIXUP (T+34) SHALL negate the quotient if the operand signs differ, negate the remainder if the dividend was negative (signed ops only), then go to DONE.
REQ-021 DONE SHALL hold res_valid=1 with result stable until res_ready=1, then return to IDLE on that edge.
REQ-022 Normal latency SHALL be res_valid first high in cycle T+35.
REQ-023 Divide-by-zero SHALL give res_valid in T+2, with quotient 0xFFFFFFFF and remainder = src1 for all four ops.
REQ-024 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0 through the normal path.
REQ-025 flush in any state SHALL force IDLE on the next edge and drop res_valid on that edge, discarding the result.
REQ-026 A new request SHALL NOT be accepted while flush is high.
REQ-027 A request SHALL be accepted no earlier than the cycle after a DONE->IDLE handshake; there is no back-to-back overlap.
REQ-028 Input operand changes after accept SHALL NOT affect the result.
REQ-029 result SHALL be 0 whenever res_valid=0.

Reset
REQ-030 Asserting reset SHALL immediately set state=IDLE, res_valid=0, busy=0 and result=0, with counter and datapath registers cleared, regardless of current state.
REQ-031 After reset is released, req_ready SHALL be 1 in the first cycle (absent flush).
REQ-032 A reset in mid-ITER SHALL leave no residual result.

Verification
REQ-033 DIV.W 7/2, then MOD.W 7/2 -> result 0x00000003 at T+35, then 0x00000001.
REQ-034 DIV.W 0xFFFFFFF9/2 -> 0xFFFFFFFD; MOD.W 0xFFFFFFF9/2 -> 0xFFFFFFFF; DIV.WU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
REQ-035 DIV.W 5/0 -> 0xFFFFFFFF at T+2; MOD.WU 5/0 -> 0x00000005; DIV.W 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-036 flush at T+10 during ITER -> IDLE at T+11, no res_valid; a new request accepted at T+11 completes with its correct value.
REQ-037 res_ready held 0 for 20 cycles in DONE -> res_valid and result stable throughout, req_ready=0; the release edge returns the controller to IDLE.
REQ-038 reset asserted asynchronously mid-ITER -> outputs are zero before the next clock edge; the subsequent 100/7 operation gives 14.
